cache_array_ctrl: RTL
=====================

// Module: cache_array_ctrl
// PURPOSE
//  Sequencer in front of one data-cache tag/data BRAM (1W/1R, registered address, unregistered q).
//  Runs a clear sweep after reset and on flush; otherwise passes the cache FSM's reads and writes through.
//  Resolves same-address read/write collisions itself; the BRAM's mixed-port read-during-write is undefined.
// PARAMETERS
//  DATA_WIDTH   19               entry width (tag+valid+dirty)
//  ADDR_WIDTH   8                index width; NUM_ENTRIES = 2**ADDR_WIDTH
//  CLEAR_VALUE  {DATA_WIDTH{0}}  value written to every entry by a sweep
// PORTS
//  clock          in   1           single clock, rising edge
//  aclr           in   1           asynchronous active-high reset; also drives the BRAM's aclr
//  ready          out  1           1 = RUN state; requests accepted only when high
//  flush_req      in   1           level/pulse; request a full clear sweep
//  flush_done     out  1           one-cycle pulse when a sweep that answered a flush_req completes
//  rd_req         in   1           read request
//  rd_addr        in   ADDR_WIDTH  read index
//  rd_valid       out  1           rd_data valid, 1 cycle after an accepted rd_req
//  rd_data        out  DATA_WIDTH  read result
//  wr_en          in   1           write request
//  wr_addr        in   ADDR_WIDTH  write index
//  wr_data        in   DATA_WIDTH  write value
//  bram_rdaddress out  ADDR_WIDTH  to BRAM read port
//  bram_rden      out  1
//  bram_wraddress out  ADDR_WIDTH  to BRAM write port
//  bram_wren      out  1
//  bram_data      out  DATA_WIDTH
//  bram_q         in   DATA_WIDTH  BRAM read data, valid 1 cycle after the address
// BEHAVIOUR
//  States: INIT, RUN, FLUSH. aclr -> INIT.
//   INIT/FLUSH: sweep counter runs 0..NUM_ENTRIES-1.
//   Each sweep cycle: bram_wren=1, bram_wraddress=counter, bram_data=CLEAR_VALUE.
//   Sweep takes exactly NUM_ENTRIES cycles; state moves to RUN on the cycle after the last index.
//  Reset values: ready=0, flush_done=0, rd_valid=0, counter=0, bypass reg=0, pending=0.
//  ready=1 only in RUN; while ready=0, rd_req and wr_en are ignored (dropped, no rd_valid).
//  RUN passthrough:
//   bram_wren=wr_en, bram_wraddress=wr_addr, bram_data=wr_data.
//   bram_rden=rd_req, bram_rdaddress=rd_addr.
//  RUN + flush_req: state -> FLUSH, pending=1.
//   Same-cycle rd_req/wr_en are still serviced (write lands before the sweep).
//  flush_req in INIT or FLUSH: sets pending; no extra sweep (no writes during a sweep).
//  Sweep end with pending=1: flush_done=1 for one cycle as ready rises; pending clears.
//  Sweep end with pending=0 (plain INIT): no flush_done pulse.
//  Read latency 1: rd_valid registered from (rd_req & ready).
//  Collision: rd_req & wr_en & rd_addr==wr_addr in the same cycle:
//   - wr_data is captured in the bypass register and a select flag is set.
//   - Next cycle rd_data = bypass register instead of bram_q.
//   - Without a collision, rd_data = bram_q (combinational).
//  Write in cycle N, read of the same index in cycle N+1: served by the BRAM (new data); no bypass.
//  aclr mid-sweep or mid-read: async return to INIT; rd_valid drops; counter restarts at 0.
//  Counter is ADDR_WIDTH bits; terminal index is all-ones; no wrap past terminal.
// STRUCTURE
//  Shared package data_cache_pkg:
//   - state encodings CA_INIT=2'd0, CA_RUN=2'd1, CA_FLUSH=2'd2;
//   - default DATA_WIDTH/ADDR_WIDTH constants.
//  Single flat module; no sub-module. The BRAM instance lives in the parent, wired to the bram_* ports.
// TESTING  (bench: ADDR_WIDTH=3, DATA_WIDTH=8, CLEAR_VALUE=8'h00, behavioural BRAM model)
//  1. Release aclr -> ready=0 for 8 cycles, bram_wren=1 with addr 0..7.
//     Then ready=1, no flush_done; reads of 0..7 return 8'h00.
//  2. RUN: write addr 5 = 8'hA5, read addr 5 next cycle.
//     -> rd_valid exactly 1 cycle after the read, rd_data=8'hA5.
//  3. Same cycle: write addr 2 = 8'h3C and read addr 2.
//     -> next cycle rd_valid=1, rd_data=8'h3C even when the BRAM model returns X.
//  4. RUN: flush_req pulse -> ready low 8 cycles.
//     -> flush_done pulses once as ready rises; all entries read 8'h00.
//     A second flush_req mid-sweep yields no extra sweep and a single flush_done.
//  5. aclr asserted at sweep index 4 -> outputs reset immediately.
//     After release: full 8-cycle sweep from index 0, no flush_done.
//  6. rd_req/wr_en during INIT -> no rd_valid; a later read of that address returns 8'h00.

Source files
------------

// File: rtl/data_cache_pkg.sv
// Shared definitions for the data-cache array sequencer: state encodings
// and the default entry/index widths.
package data_cache_pkg;

    typedef enum logic [1:0] {
        CA_INIT  = 2'd0,
        CA_RUN   = 2'd1,
        CA_FLUSH = 2'd2
    } ca_state_t;

    localparam int DC_DATA_WIDTH = 19;
    localparam int DC_ADDR_WIDTH = 8;

endpackage

// File: rtl/cache_array_ctrl.sv
// Sequencer in front of a 1W/1R tag/data BRAM: clears every entry after reset
// and on flush, otherwise passes reads/writes through and bypasses same-address collisions.
module cache_array_ctrl
    import data_cache_pkg::*;
#(
    parameter int DATA_WIDTH = DC_DATA_WIDTH,
    parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  aclr,
    output logic                  ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [ADDR_WIDTH-1:0] bram_rdaddress,
    output logic                  bram_rden,
    output logic [ADDR_WIDTH-1:0] bram_wraddress,
    output logic                  bram_wren,
    output logic [DATA_WIDTH-1:0] bram_data,
    input  logic [DATA_WIDTH-1:0] bram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = '1;

    ca_state_t             state, state_next;
    logic [ADDR_WIDTH-1:0] counter, counter_next;
    logic                  pending, pending_next;
    logic                  flush_done_next;
    logic                  bypass_sel;
    logic [DATA_WIDTH-1:0] bypass_data;
    logic                  collision;

    assign ready = (state == CA_RUN);

    // The BRAM's read-during-write result is undefined, so a same-cycle
    // same-index read is answered from the captured write data instead.
    assign collision = ready && rd_req && wr_en && (rd_addr == wr_addr);
    assign rd_data   = bypass_sel ? bypass_data : bram_q;

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state       <= CA_INIT;
            counter     <= '0;
            pending     <= 1'b0;
            flush_done  <= 1'b0;
            rd_valid    <= 1'b0;
            bypass_sel  <= 1'b0;
            bypass_data <= '0;
        end else begin
            state       <= state_next;
            counter     <= counter_next;
            pending     <= pending_next;
            flush_done  <= flush_done_next;
            rd_valid    <= rd_req && ready;
            bypass_sel  <= collision;
            if (collision) begin
                bypass_data <= wr_data;
            end
        end
    end

    always_comb begin
        state_next      = state;
        counter_next    = counter;
        pending_next    = pending;
        flush_done_next = 1'b0;
        bram_wren       = 1'b0;
        bram_wraddress  = wr_addr;
        bram_data       = wr_data;
        bram_rden       = 1'b0;
        bram_rdaddress  = rd_addr;

        case (state)
            CA_RUN: begin
                bram_wren = wr_en;
                bram_rden = rd_req;
                if (flush_req) begin
                    state_next   = CA_FLUSH;
                    pending_next = 1'b1;
                    counter_next = '0;
                end
            end
            CA_INIT, CA_FLUSH: begin
                bram_wren      = 1'b1;
                bram_wraddress = counter;
                bram_data      = CLEAR_VALUE;
                if (flush_req) begin
                    pending_next = 1'b1;
                end
                // A flush requested during any sweep is answered by that sweep.
                if (counter == LAST_INDEX) begin
                    state_next      = CA_RUN;
                    counter_next    = '0;
                    flush_done_next = pending || flush_req;
                    pending_next    = 1'b0;
                end else begin
                    counter_next = counter + 1'b1;
                end
            end
            default: begin
                state_next   = CA_INIT;
                counter_next = '0;
            end
        endcase
    end

endmodule
